// File: rtl/mest_pro_run_ctrl_if.sv
// Control/result bundle between the run sequencer (master) and one mest_pro core (slave).
// The sequencer is the only driver of the core's reset, memory-reset and start pins.
interface mest_pro_run_ctrl_if #(
  parameter int RESULT_WIDTH = 8
);
  logic                    core_reset_n;
  logic                    memory_reset;
  logic                    start;
  logic [RESULT_WIDTH-1:0] result;
  logic                    valid_result;
  logic                    carry;
  logic                    zero_flag;
  logic                    all_done;

  modport master (
    output core_reset_n, memory_reset, start,
    input  result, valid_result, carry, zero_flag, all_done
  );

  modport slave (
    input  core_reset_n, memory_reset, start,
    output result, valid_result, carry, zero_flag, all_done
  );
endinterface

// File: rtl/mest_pro_run_ctrl.sv
// Run sequencer for one mest_pro core: clear, start strobe, supervised run with watchdog,
// and per-run result statistics. All outputs come straight from flops.
module mest_pro_run_ctrl #(
  parameter int RESULT_WIDTH   = 8,
  parameter int MEM_RST_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    i_reset,
  mest_pro_run_ctrl_if.master     core,
  input  logic                    i_go,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic [CNT_WIDTH-1:0]    o_result_count,
  output logic [RESULT_WIDTH-1:0] o_last_result,
  output logic [RESULT_WIDTH-1:0] o_checksum,
  output logic                    o_carry_seen,
  output logic                    o_zero_seen,
  output logic [CNT_WIDTH-1:0]    o_cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int                    CLR_W    = (MEM_RST_CYCLES > 1) ? $clog2(MEM_RST_CYCLES) : 1;
  localparam logic [CLR_W-1:0]      CLR_LAST = CLR_W'(MEM_RST_CYCLES - 1);
  localparam logic [CLR_W-1:0]      CLR_ZERO = {CLR_W{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  TMO_CNT  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [RESULT_WIDTH-1:0] RES_ZERO = {RESULT_WIDTH{1'b0}};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  state_e                  state_q, state_d;
  logic [CLR_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic                    core_reset_n_q, core_reset_n_d;
  logic                    memory_reset_q, memory_reset_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]    result_count_q, result_count_d;
  logic [RESULT_WIDTH-1:0] last_result_q, last_result_d;
  logic [RESULT_WIDTH-1:0] checksum_q, checksum_d;
  logic                    carry_seen_q, carry_seen_d;
  logic                    zero_seen_q, zero_seen_d;
  logic [CNT_WIDTH-1:0]    cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0]    cycles_inc_s;

  // Next-state, statistics and output decode; control pins follow the next state so they are registered.
  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    timeout_d      = timeout_q;
    result_count_d = result_count_q;
    last_result_d  = last_result_q;
    checksum_d     = checksum_q;
    carry_seen_d   = carry_seen_q;
    zero_seen_d    = zero_seen_q;
    cycles_d       = cycles_q;
    cycles_inc_s   = sat_inc(cycles_q);

    case (state_q)
      S_IDLE: begin
        if (i_go) begin
          state_d        = S_CLR;
          clr_cnt_d      = CLR_ZERO;
          timeout_d      = 1'b0;
          result_count_d = CNT_ZERO;
          last_result_d  = RES_ZERO;
          checksum_d     = RES_ZERO;
          carry_seen_d   = 1'b0;
          zero_seen_d    = 1'b0;
          cycles_d       = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = S_START;
        end else begin
          clr_cnt_d = clr_cnt_q + {{(CLR_W-1){1'b0}}, 1'b1};
        end
      end
      S_START: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort freezes the statistics, so nothing from this cycle is accumulated.
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          cycles_d = cycles_inc_s;
          if (core.valid_result) begin
            result_count_d = sat_inc(result_count_q);
            last_result_d  = core.result;
            checksum_d     = checksum_q + core.result;
            carry_seen_d   = carry_seen_q | core.carry;
            zero_seen_d    = zero_seen_q | core.zero_flag;
          end else begin
            result_count_d = result_count_q;
          end
          if (core.all_done) begin
            state_d = S_DONE;
          end else if (cycles_inc_s >= TMO_CNT) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d         = (state_d != S_IDLE);
    core_reset_n_d = (state_d != S_CLR);
    memory_reset_d = (state_d == S_CLR);
    start_d        = (state_d == S_START);
    done_d         = (state_d == S_DONE);
  end

  // State and every output flop, with synchronous reset holding the core in reset.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      clr_cnt_q      <= CLR_ZERO;
      core_reset_n_q <= 1'b0;
      memory_reset_q <= 1'b0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      result_count_q <= CNT_ZERO;
      last_result_q  <= RES_ZERO;
      checksum_q     <= RES_ZERO;
      carry_seen_q   <= 1'b0;
      zero_seen_q    <= 1'b0;
      cycles_q       <= CNT_ZERO;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      core_reset_n_q <= core_reset_n_d;
      memory_reset_q <= memory_reset_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      result_count_q <= result_count_d;
      last_result_q  <= last_result_d;
      checksum_q     <= checksum_d;
      carry_seen_q   <= carry_seen_d;
      zero_seen_q    <= zero_seen_d;
      cycles_q       <= cycles_d;
    end
  end

  assign core.core_reset_n = core_reset_n_q;
  assign core.memory_reset = memory_reset_q;
  assign core.start        = start_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_timeout         = timeout_q;
  assign o_result_count    = result_count_q;
  assign o_last_result     = last_result_q;
  assign o_checksum        = checksum_q;
  assign o_carry_seen      = carry_seen_q;
  assign o_zero_seen       = zero_seen_q;
  assign o_cycles          = cycles_q;

endmodule
